// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned multiply/divide execute unit that sits behind the
//   register file. It accepts two read operands and a destination address.
//   It produces one result per operation and a one-cycle write strobe for the
//   register-file write port.
//
//   Ops: 00 MUL (low product), 01 MULHU (high product),
//        10 DIVU (quotient),   11 REMU (remainder)
//
//   Ports
//     CLK, RESET        clock, asynchronous active-low reset
//     Start             request, sampled only while idle
//     Op                operation select
//     OperandA/B        multiplicand/dividend, multiplier/divisor
//     DestAddr          destination register
//     Busy              high from the accept edge through the Done cycle
//     Done / RegWr      one-cycle completion / write-enable pulse
//     Result            result, held until the next completion
//     ResultAddr        destination of Result
//
//   Optional build macro: MULDIV_EARLY_OUT_EN
//     When it is defined, a multiply finishes as soon as the remaining
//     multiplier bits are all zero. A multiply with B=0 finishes like a
//     divide by zero. Division timing does not change.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [WIDTH-1:0]  OperandA,
    input  logic [WIDTH-1:0]  OperandB,
    input  logic [ADDR_W-1:0] DestAddr,
    output logic              Busy,
    output logic              Done,
    output logic              RegWr,
    output logic [WIDTH-1:0]  Result,
    output logic [ADDR_W-1:0] ResultAddr
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    // Multiply datapath: the multiplicand shifts left and the multiplier shifts right.
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [2*WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    // Divide datapath: the dividend shifts out of quo_q while quotient bits shift in.
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    // Registered outputs
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [ADDR_W-1:0]   result_addr_q, result_addr_d;

    // Iteration datapath signals
    logic [2*WIDTH-1:0]  mul_sum_s;
    logic [WIDTH:0]      shifted_s;
    logic [WIDTH:0]      diff_s;
    logic                take_s;

    // One shift-add step and one restoring-division step, computed from the current state.
    always_comb begin
        mul_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        shifted_s = {rem_q, quo_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, divisor_q};
        // The partial remainder is always below 2*divisor. Bit WIDTH of the
        // difference is therefore set exactly when the subtraction underflows.
        take_s    = ~diff_s[WIDTH];
    end

    // Next-state logic and datapath updates for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        op_d          = op_q;
        dest_d        = dest_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        divisor_d     = divisor_q;
        done_d        = 1'b0;
        result_d      = result_q;
        result_addr_d = result_addr_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d      = Op;
                    dest_d    = DestAddr;
                    count_d   = CNT_FULL;
                    acc_d     = {(2*WIDTH){1'b0}};
                    mcand_d   = {{WIDTH{1'b0}}, OperandA};
                    mplier_d  = OperandB;
                    rem_d     = {WIDTH{1'b0}};
                    quo_d     = OperandA;
                    divisor_d = OperandB;
                    if (Op[1] && (OperandB == {WIDTH{1'b0}})) begin
                        // Divide by zero returns an all-ones quotient and the
                        // dividend as the remainder. No iterations are run.
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = OperandA;
                        state_d = S_DONE;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (OperandB == {WIDTH{1'b0}}) begin
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                count_d = count_q - CNT_ONE;
                if (op_q[1]) begin
                    rem_d = take_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], take_s};
                end else begin
                    acc_d    = mul_sum_s;
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end
                if (count_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
`ifdef MULDIV_EARLY_OUT_EN
                else if (!op_q[1] && (mplier_d == {WIDTH{1'b0}})) begin
                    state_d = S_DONE;
                end
`endif
                else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                done_d        = 1'b1;
                result_addr_d = dest_q;
                case (op_q)
                    2'b00:   result_d = acc_q[WIDTH-1:0];
                    2'b01:   result_d = acc_q[2*WIDTH-1:WIDTH];
                    2'b10:   result_d = quo_q;
                    2'b11:   result_d = rem_q;
                    default: result_d = {WIDTH{1'b0}};
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Busy stays high through the cycle in which the Done pulse is visible.
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= S_IDLE;
            count_q       <= {CNT_W{1'b0}};
            op_q          <= 2'b00;
            dest_q        <= {ADDR_W{1'b0}};
            acc_q         <= {(2*WIDTH){1'b0}};
            mcand_q       <= {(2*WIDTH){1'b0}};
            mplier_q      <= {WIDTH{1'b0}};
            rem_q         <= {WIDTH{1'b0}};
            quo_q         <= {WIDTH{1'b0}};
            divisor_q     <= {WIDTH{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= {WIDTH{1'b0}};
            result_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            op_q          <= op_d;
            dest_q        <= dest_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            divisor_q     <= divisor_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            result_addr_q <= result_addr_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign RegWr      = done_q;
    assign Result     = result_q;
    assign ResultAddr = result_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit. The stimulus pushes the expected result,
// address and completion cycle. The monitor compares each Done pulse against
// the head of the queue.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA, OperandB;
    logic [4:0]  DestAddr;
    logic        Busy, Done, RegWr;
    logic [31:0] Result;
    logic [4:0]  ResultAddr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .DestAddr(DestAddr),
        .Busy(Busy), .Done(Done), .RegWr(RegWr),
        .Result(Result), .ResultAddr(ResultAddr)
    );

    always #5 CLK = ~CLK;

    // Count active edges so that completion times can be predicted.
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference arithmetic
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Number of edges from the accept edge to the edge after which Done is visible.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
        int lat;
        lat = 33;
        if (op[1] && b == 32'd0) lat = 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            lat = 1;
            for (int i = 31; i >= 0; i--)
                if (b[i] && lat == 1) lat = 2 + i;
        end
`endif
        return lat;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: Done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", Result, e.res);
                check("result_addr", 32'(ResultAddr), 32'(e.addr));
                check("done_cycle", 32'(cyc), 32'(e.at));
                check("regwr", 32'(RegWr), 32'd1);
            end
        end
    end

    // Issue one operation. The caller must sit just after a negedge while the
    // unit can accept. Optional Start pulses with junk operands are driven
    // during RUN. With wait_done set, the task returns at the negedge where
    // Done is seen.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input int pulses, input bit wait_done);
        int lat;
        bit seen;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b; DestAddr = dest;
        @(posedge CLK); #1;
        lat = ref_lat(op, b);
        exp_q.push_back('{res: ref_res(op, a, b), addr: dest, at: cyc + lat});
        Start = 1'b0;
        OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom); DestAddr = 5'($urandom);
        if (lat > 25) begin
            for (int i = 0; i < pulses; i++) begin
                @(negedge CLK);
                Start = 1'($urandom); OperandA = $urandom; OperandB = $urandom;
                Op = 2'($urandom); DestAddr = 5'($urandom);
            end
        end
        @(negedge CLK);
        Start = 1'b0;
        if (wait_done) begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (Done === 1'b1) seen = 1'b1;
                else @(negedge CLK);
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no Done expected Done within 100 cycles");
            end
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        RESET = 1'b0; Start = 1'b0; Op = 2'b00;
        OperandA = 32'd0; OperandB = 32'd0; DestAddr = 5'd0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_regwr", 32'(RegWr), 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_addr", 32'(ResultAddr), 32'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_done", 32'(Done), 32'd0);

        // Directed cases
        do_op(2'b00, 32'h0000_FFFF, 32'h0001_0001, 5'd3, 0, 1'b1);
        @(negedge CLK);
        check("busy_after_done", 32'(Busy), 32'd0);
        check("done_one_cycle", 32'(Done), 32'd0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 1'b1);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 1'b1);
        do_op(2'b10, 32'd100, 32'd7, 5'd6, 0, 1'b1);
        do_op(2'b11, 32'd100, 32'd7, 5'd7, 0, 1'b1);
        do_op(2'b10, 32'd5, 32'd0, 5'd8, 0, 1'b1);
        do_op(2'b11, 32'd5, 32'd0, 5'd9, 0, 1'b1);
        do_op(2'b00, 32'h1234_5678, 32'd1, 5'd10, 0, 1'b1);
        // Start pulses while running are ignored.
        do_op(2'b10, 32'hDEAD_BEEF, 32'd13, 5'd11, 20, 1'b1);
        @(negedge CLK);
        check("busy_after_pulses", 32'(Busy), 32'd0);

        // Random operations. Some are issued back-to-back in the Done cycle.
        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 5'($urandom), int'($urandom_range(0, 12)), 1'b1);
            if ($urandom_range(0, 1) == 0) @(negedge CLK);
        end

        // Reset in the middle of a divide: no write may follow.
        @(negedge CLK);
        do_op(2'b10, 32'h8765_4321, 32'd3, 5'd12, 0, 1'b0);
        repeat (8) @(negedge CLK);
        RESET = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_regwr", 32'(RegWr), 32'd0);
        check("midrst_result", Result, 32'd0);
        check("midrst_addr", 32'(ResultAddr), 32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (40) @(negedge CLK);
        do_op(2'b11, 32'd1000, 32'd33, 5'd13, 0, 1'b1);
        repeat (2) @(negedge CLK);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
